// File: rtl/nic2noc_vc_out_stage.sv
// NIC-to-NoC output stage: per-VC pointer FSMs, downstream credit counters and a registered flit output.
// Optional sticky error flags on err_o are built in when NIC_OUT_ERR_EN is defined.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module nic2noc_vc_out_stage #(
   parameter int N_TOT_OF_VC    = 6,
   parameter int N_BITS_POINTER = 5,
   parameter int FLIT_W         = `FLIT_WIDTH,
   parameter int CREDIT_DEPTH   = 4,
   parameter int N_BITS_CREDIT  = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [N_TOT_OF_VC-1:0]                credit_signal_i,
   input  logic [N_TOT_OF_VC-1:0]                free_signal_i,
   output logic [FLIT_W-1:0]                     out_link_o,
   output logic                                  is_valid_o,
   output logic [N_TOT_OF_VC-1:0]                out_vc_o,
   input  logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_i,
   input  logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_i,
   input  logic [N_TOT_OF_VC-1:0]                release_pointer_i,
   output logic [N_TOT_OF_VC-1:0]                credit_signal_o,
   output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] fifo_pointed_o,
   input  logic [FLIT_W-1:0]                     in_link_i,
   input  logic [N_TOT_OF_VC-1:0]                in_vc_i,
   input  logic                                  is_valid_i,
   input  logic                                  is_tail_i,
   output logic [N_TOT_OF_VC-1:0]                in_ready_o,
   output logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_o
`ifdef NIC_OUT_ERR_EN
   ,
   output logic [3:0]                            err_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT_FREE} vc_state_e;

   localparam logic [N_BITS_CREDIT-1:0] CRED_MAX = N_BITS_CREDIT'(CREDIT_DEPTH);
   localparam logic [N_BITS_CREDIT-1:0] CRED_ONE = N_BITS_CREDIT'(1);
   localparam logic [N_TOT_OF_VC-1:0]   VC_ONE   = N_TOT_OF_VC'(1);

   vc_state_e                 state_q  [N_TOT_OF_VC];
   vc_state_e                 state_d  [N_TOT_OF_VC];
   logic [N_BITS_CREDIT-1:0]  credit_q [N_TOT_OF_VC];
   logic [N_BITS_CREDIT-1:0]  credit_d [N_TOT_OF_VC];
   logic [N_BITS_POINTER-1:0] ptr_q    [N_TOT_OF_VC];
   logic [N_BITS_POINTER-1:0] ptr_d    [N_TOT_OF_VC];
   logic [N_TOT_OF_VC-1:0]    prop_q, prop_d;
   logic [FLIT_W-1:0]         out_link_q, out_link_d;
   logic [N_TOT_OF_VC-1:0]    out_vc_q, out_vc_d;
   logic                      is_valid_q, is_valid_d;

   logic                      vc_onehot;
   logic [N_TOT_OF_VC-1:0]    accept_vc;
   logic [N_TOT_OF_VC-1:0]    busy;
   logic [N_TOT_OF_VC-1:0]    at_max;

   always_comb begin
      vc_onehot  = (in_vc_i != '0) && ((in_vc_i & (in_vc_i - VC_ONE)) == '0);
      in_ready_o = '0;
      busy       = '0;
      at_max     = '0;
      for (int i = 0; i < N_TOT_OF_VC; i++) begin
         in_ready_o[i] = (state_q[i] == S_ACTIVE) && (credit_q[i] != '0);
         busy[i]       = (state_q[i] != S_IDLE);
         at_max[i]     = (credit_q[i] == CRED_MAX);
      end
      accept_vc = in_vc_i & in_ready_o & {N_TOT_OF_VC{is_valid_i & vc_onehot}};

      for (int i = 0; i < N_TOT_OF_VC; i++) begin
         state_d[i]  = state_q[i];
         ptr_d[i]    = ptr_q[i];
         credit_d[i] = credit_q[i];
         prop_d[i]   = prop_q[i];

         if (accept_vc[i] && !credit_signal_i[i])
            credit_d[i] = credit_q[i] - CRED_ONE;
         else if (!accept_vc[i] && credit_signal_i[i] && !at_max[i])
            credit_d[i] = credit_q[i] + CRED_ONE;

         unique case (state_q[i])
            S_IDLE: if (g_fifo_pointer_i[i]) begin
               state_d[i] = S_ACTIVE;
               ptr_d[i]   = g_fifo_out_buffer_id_i[i*N_BITS_POINTER +: N_BITS_POINTER];
            end
            S_ACTIVE: if (accept_vc[i] && is_tail_i) state_d[i] = S_WAIT_FREE;
            S_WAIT_FREE: if (free_signal_i[i]) state_d[i] = S_IDLE;
            default: state_d[i] = S_IDLE;
         endcase

         // An honoured grant must win over a simultaneous release.
         if (g_fifo_pointer_i[i] && (state_q[i] == S_IDLE))
            prop_d[i] = 1'b1;
         else if (release_pointer_i[i])
            prop_d[i] = 1'b0;
      end

      is_valid_d = |accept_vc;
      out_link_d = is_valid_d ? in_link_i : out_link_q;
      out_vc_d   = is_valid_d ? in_vc_i   : out_vc_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_TOT_OF_VC; i++) begin
            state_q[i]  <= S_IDLE;
            credit_q[i] <= CRED_MAX;
            ptr_q[i]    <= '0;
         end
         prop_q     <= '0;
         out_link_q <= '0;
         out_vc_q   <= '0;
         is_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_TOT_OF_VC; i++) begin
            state_q[i]  <= state_d[i];
            credit_q[i] <= credit_d[i];
            ptr_q[i]    <= ptr_d[i];
         end
         prop_q     <= prop_d;
         out_link_q <= out_link_d;
         out_vc_q   <= out_vc_d;
         is_valid_q <= is_valid_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N_TOT_OF_VC; i++)
         fifo_pointed_o[i*N_BITS_POINTER +: N_BITS_POINTER] = ptr_q[i];
   end

   assign fifo_pointer_state_o = busy;
   assign credit_signal_o      = credit_signal_i & prop_q;
   assign out_link_o           = out_link_q;
   assign out_vc_o             = out_vc_q;
   assign is_valid_o           = is_valid_q;

`ifdef NIC_OUT_ERR_EN
   logic [3:0] err_q, err_d;

   // bit2 flags only credits that are actually discarded at saturation.
   always_comb begin
      err_d = err_q | {|(g_fifo_pointer_i & busy),
                       |(credit_signal_i & at_max & ~accept_vc),
                       is_valid_i & ~vc_onehot,
                       is_valid_i & ~(|accept_vc)};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= '0;
      else      err_q <= err_d;
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_nic2noc_vc_out_stage.sv
// Directed bench for nic2noc_vc_out_stage with a per-cycle behavioural model and literal checkpoints.
`timescale 1ns/1ps
module tb_nic2noc_vc_out_stage;
   localparam int N = 6;
   localparam int P = 5;
   localparam int W = 32;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   credit_signal_i, free_signal_i, g_fifo_pointer_i, release_pointer_i, in_vc_i;
   logic [N*P-1:0] g_fifo_out_buffer_id_i;
   logic [W-1:0]   in_link_i;
   logic           is_valid_i, is_tail_i;
   logic [W-1:0]   out_link_o;
   logic           is_valid_o;
   logic [N-1:0]   out_vc_o, credit_signal_o, in_ready_o, fifo_pointer_state_o;
   logic [N*P-1:0] fifo_pointed_o;
`ifdef NIC_OUT_ERR_EN
   logic [3:0]     err_o;
`endif

   int total = 0;
   int bad   = 0;

   nic2noc_vc_out_stage #(.N_TOT_OF_VC(N), .N_BITS_POINTER(P), .FLIT_W(W),
                          .CREDIT_DEPTH(DEPTH), .N_BITS_CREDIT(3)) dut (
`ifdef NIC_OUT_ERR_EN
      .err_o(err_o),
`endif
      .clk(clk), .rst(rst),
      .credit_signal_i(credit_signal_i), .free_signal_i(free_signal_i),
      .out_link_o(out_link_o), .is_valid_o(is_valid_o), .out_vc_o(out_vc_o),
      .g_fifo_pointer_i(g_fifo_pointer_i), .g_fifo_out_buffer_id_i(g_fifo_out_buffer_id_i),
      .release_pointer_i(release_pointer_i), .credit_signal_o(credit_signal_o),
      .fifo_pointed_o(fifo_pointed_o), .in_link_i(in_link_i), .in_vc_i(in_vc_i),
      .is_valid_i(is_valid_i), .is_tail_i(is_tail_i), .in_ready_o(in_ready_o),
      .fifo_pointer_state_o(fifo_pointer_state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a VC is "bound" from an honoured grant until free after its tail.
   int         m_cred  [N];
   bit         m_bound [N];
   bit         m_tail  [N];
   bit         m_prop  [N];
   logic [P-1:0] m_ptr [N];
   bit         exp_valid;
   logic [W-1:0] exp_link;
   logic [N-1:0] exp_vc;
   logic [3:0] m_err;
   bit         oh, acc_any;
   bit [N-1:0] acc;

   always @(posedge clk or negedge rst) begin : model
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            m_cred[i] = DEPTH; m_bound[i] = 0; m_tail[i] = 0; m_prop[i] = 0; m_ptr[i] = '0;
         end
         exp_valid = 0; exp_link = '0; exp_vc = '0; m_err = '0;
      end else begin
         oh = is_valid_i && ($countones(in_vc_i) == 1);
         for (int i = 0; i < N; i++)
            acc[i] = oh && in_vc_i[i] && m_bound[i] && !m_tail[i] && (m_cred[i] > 0);
         acc_any = |acc;
         if (is_valid_i && !acc_any) m_err[0] = 1'b1;
         if (is_valid_i && !oh)      m_err[1] = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (credit_signal_i[i] && m_cred[i] == DEPTH && !acc[i]) m_err[2] = 1'b1;
            if (g_fifo_pointer_i[i] && m_bound[i]) m_err[3] = 1'b1;
            if (acc[i] && !credit_signal_i[i]) m_cred[i] = m_cred[i] - 1;
            else if (!acc[i] && credit_signal_i[i] && m_cred[i] < DEPTH) m_cred[i] = m_cred[i] + 1;
            if (!m_bound[i] && g_fifo_pointer_i[i]) begin
               m_bound[i] = 1; m_tail[i] = 0; m_prop[i] = 1;
               m_ptr[i] = g_fifo_out_buffer_id_i[i*P +: P];
            end else begin
               if (release_pointer_i[i]) m_prop[i] = 0;
               if (m_bound[i] && !m_tail[i] && acc[i] && is_tail_i) m_tail[i] = 1;
               else if (m_bound[i] && m_tail[i] && free_signal_i[i]) begin
                  m_bound[i] = 0; m_tail[i] = 0;
               end
            end
         end
         exp_valid = acc_any;
         if (acc_any) begin exp_link = in_link_i; exp_vc = in_vc_i; end
      end
   end

   always @(negedge clk) begin : compare
      logic [N*P-1:0] ep;
      logic [N-1:0]   er, eb, ecs;
      for (int i = 0; i < N; i++) begin
         er[i]  = m_bound[i] && !m_tail[i] && (m_cred[i] > 0);
         eb[i]  = m_bound[i];
         ecs[i] = credit_signal_i[i] && m_prop[i];
         ep[i*P +: P] = m_ptr[i];
      end
      chk("is_valid_o", 64'(is_valid_o), 64'(exp_valid));
      chk("out_link_o", 64'(out_link_o), 64'(exp_link));
      chk("out_vc_o", 64'(out_vc_o), 64'(exp_vc));
      chk("in_ready_o", 64'(in_ready_o), 64'(er));
      chk("fifo_pointer_state_o", 64'(fifo_pointer_state_o), 64'(eb));
      chk("fifo_pointed_o", 64'(fifo_pointed_o), 64'(ep));
      chk("credit_signal_o", 64'(credit_signal_o), 64'(ecs));
`ifdef NIC_OUT_ERR_EN
      chk("err_o", 64'(err_o), 64'(m_err));
`endif
   end

   task automatic idle_in();
      credit_signal_i = '0; free_signal_i = '0; g_fifo_pointer_i = '0; release_pointer_i = '0;
      g_fifo_out_buffer_id_i = '0; in_link_i = '0; in_vc_i = '0; is_valid_i = 0; is_tail_i = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic grant(input int vc, input logic [P-1:0] id);
      g_fifo_pointer_i = '0;
      g_fifo_pointer_i[vc] = 1'b1;
      g_fifo_out_buffer_id_i = '0;
      g_fifo_out_buffer_id_i[vc*P +: P] = id;
   endtask

   task automatic flit(input int vc, input logic [W-1:0] data, input logic tail);
      in_vc_i = '0; in_vc_i[vc] = 1'b1;
      in_link_i = data; is_valid_i = 1'b1; is_tail_i = tail;
   endtask

   initial begin
      rst = 1'b0;
      idle_in();
      cyc(); cyc();
      chk("rst is_valid_o", 64'(is_valid_o), 64'd0);
      chk("rst out_link_o", 64'(out_link_o), 64'd0);
      chk("rst state", 64'(fifo_pointer_state_o), 64'd0);
      rst = 1'b1;
      cyc();

      grant(2, 5'd5); cyc(); idle_in();
      chk("grant state", 64'(fifo_pointer_state_o), 64'h04);
      chk("grant ptr2", 64'(fifo_pointed_o[14:10]), 64'd5);
      chk("grant ready2", 64'(in_ready_o[2]), 64'd1);

      for (int k = 0; k < 4; k++) begin
         flit(2, 32'hA000_0000 + 32'(k), 1'b0); cyc();
         chk("burst valid", 64'(is_valid_o), 64'd1);
         chk("burst data", 64'(out_link_o), 64'hA000_0000 + 64'(k));
         chk("burst ready2", 64'(in_ready_o[2]), (k < 3) ? 64'd1 : 64'd0);
      end
      flit(2, 32'hA000_0004, 1'b0); cyc();
      chk("drop valid", 64'(is_valid_o), 64'd0);
      chk("drop hold", 64'(out_link_o), 64'hA000_0003);

      flit(2, 32'hB000_0000, 1'b0); credit_signal_i = 6'b000100; cyc();
      credit_signal_i = '0;
      chk("cred+flit valid", 64'(is_valid_o), 64'd0);
      chk("cred+flit ready2", 64'(in_ready_o[2]), 64'd1);
      flit(2, 32'hB000_0001, 1'b0); cyc();
      chk("after cred valid", 64'(is_valid_o), 64'd1);
      chk("after cred ready2", 64'(in_ready_o[2]), 64'd0);

      idle_in(); credit_signal_i = 6'b000100; cyc();
      idle_in(); flit(2, 32'hC000_0000, 1'b1); cyc(); idle_in();
      chk("tail valid", 64'(is_valid_o), 64'd1);
      chk("tail ready2", 64'(in_ready_o[2]), 64'd0);
      chk("tail state2", 64'(fifo_pointer_state_o[2]), 64'd1);
      free_signal_i = 6'b000100; cyc(); idle_in();
      chk("free state2", 64'(fifo_pointer_state_o[2]), 64'd0);
      grant(2, 5'd9); cyc(); idle_in();
      chk("regrant ptr2", 64'(fifo_pointed_o[14:10]), 64'd9);
      grant(2, 5'd3); free_signal_i = 6'b000100; cyc(); idle_in();
      chk("busy grant ptr2", 64'(fifo_pointed_o[14:10]), 64'd9);
      chk("active free state2", 64'(fifo_pointer_state_o[2]), 64'd1);

      grant(0, 5'd7); cyc(); idle_in();
      credit_signal_i = 6'b000001; #1;
      chk("fwd credit", 64'(credit_signal_o), 64'h01);
      cyc(); credit_signal_i = '0;
      release_pointer_i = 6'b000001; cyc(); idle_in();
      credit_signal_i = 6'b000001; #1;
      chk("released credit", 64'(credit_signal_o), 64'h00);
      cyc(); idle_in();
      for (int k = 0; k < 4; k++) begin
         flit(0, 32'hD000_0000 + 32'(k), 1'b0); cyc();
         chk("sat ready0", 64'(in_ready_o[0]), (k < 3) ? 64'd1 : 64'd0);
      end
      idle_in(); in_vc_i = 6'b000011; is_valid_i = 1'b1; in_link_i = 32'hEEEE_EEEE; cyc(); idle_in();
      chk("non-onehot valid", 64'(is_valid_o), 64'd0);
`ifdef NIC_OUT_ERR_EN
      chk("err all", 64'(err_o), 64'hF);
`endif

      credit_signal_i = 6'b000100; cyc(); cyc(); idle_in();
      flit(2, 32'hE000_0000, 1'b0); cyc();
      chk("pre-rst valid", 64'(is_valid_o), 64'd1);
      flit(2, 32'hE000_0001, 1'b0);
      #4 rst = 1'b0;
      #1;
      chk("async rst valid", 64'(is_valid_o), 64'd0);
      chk("async rst state", 64'(fifo_pointer_state_o), 64'd0);
      chk("async rst link", 64'(out_link_o), 64'd0);
      idle_in(); cyc();
      rst = 1'b1; cyc();
      grant(2, 5'd1); cyc(); idle_in();
      for (int k = 0; k < 4; k++) begin
         flit(2, 32'hF000_0000 + 32'(k), 1'b0); cyc();
         chk("post-rst ready2", 64'(in_ready_o[2]), (k < 3) ? 64'd1 : 64'd0);
      end
      idle_in(); cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
